// File: rtl/sub_bytes_iter.sv
`default_nettype none
// ============================================================================
// Module   : sub_bytes_iter
// Function : Iterative AES SubBytes over a 128-bit state, BYTES_PER_CYCLE
//            forward S-boxes per clock, valid/ready on both sides.
// Revision : 1.0
// ============================================================================
module sub_bytes_iter #(
   parameter int BYTES_PER_CYCLE = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] state_sb_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] state_sb_out,
   output logic         busy
);

   localparam int NUM_STEPS = 16 / BYTES_PER_CYCLE;
   localparam int unsigned c_step_w = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
   localparam int unsigned c_grp_w = 8 * BYTES_PER_CYCLE;
   localparam logic [c_step_w-1:0] c_last_step = c_step_w'(NUM_STEPS - 1);

   // FIPS-197 forward S-box; element 0 is the leftmost byte of the literal.
   localparam logic [0:255][7:0] c_sbox = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   generate
      if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
          BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_param
         $fatal(1, "sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [c_step_w-1:0]   r_step;
   logic [127:0]          r_work;
   logic [c_grp_w-1:0]    w_group_in;
   logic [c_grp_w-1:0]    w_group_out;
   logic                  w_accept;

   // Select the byte group addressed by the step counter.
   always_comb begin
      w_group_in = '0;
      for (int s = 0; s < NUM_STEPS; s++) begin
         if (r_step == c_step_w'(s)) begin
            w_group_in = r_work[s*c_grp_w +: c_grp_w];
         end
      end
   end

   generate
      for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_sbox
         assign w_group_out[j*8 +: 8] = c_sbox[w_group_in[j*8 +: 8]];
      end
   endgenerate

   always_comb begin
      w_next_state = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      busy         = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_next_state = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (r_step == c_last_step) begin
               w_next_state = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) begin
               w_next_state = in_valid ? RUN : IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   assign w_accept     = in_valid & in_ready;
   assign state_sb_out = r_work;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_step  <= '0;
         r_work  <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_work <= state_sb_in;
            r_step <= '0;
         end else if (r_state == RUN) begin
            r_step <= r_step + c_step_w'(1);
            for (int s = 0; s < NUM_STEPS; s++) begin
               if (r_step == c_step_w'(s)) begin
                  r_work[s*c_grp_w +: c_grp_w] <= w_group_out;
               end
            end
         end
      end
   end

endmodule
`default_nettype wire
